// File: rtl/page_walker.sv
// page_walker: two-level hardware page-table walker feeding a TLB.
// A TLB miss (VPN) is accepted when idle. The walker then reads the level-1 and
// level-2 PTEs over a request/response memory port. It finishes with a one-cycle
// TLB fill strobe or a one-cycle page-fault pulse. Only one walk runs at a time.
// Optional build macro PAGE_WALKER_SUPERPAGE_EN: a valid level-1 PTE with the L
// bit set ends the walk as a superpage leaf. A misaligned superpage faults.
//
// Handshakes: a request transfers on a clock edge where mem_req_valid and
// mem_req_ready are both high. While mem_req_valid is high, mem_req_addr is held
// stable. A miss transfers on an edge where miss_valid and miss_ready are both
// high. mem_resp_valid is honoured only in the cycles after the request handshake.
// Address layout assumes page_offset_bits == level_bits + 2 (4-byte PTEs).
module page_walker #(
    parameter int ram_address_width = 32,
    parameter int page_offset_bits  = 12,
    parameter int level_bits        = 10,
    parameter int pte_width         = 32,
    localparam int paw              = ram_address_width - page_offset_bits
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [paw-1:0]               root_ppn,
    input  logic                         miss_valid,
    output logic                         miss_ready,
    input  logic [paw-1:0]               miss_vpn,
    output logic                         mem_req_valid,
    input  logic                         mem_req_ready,
    output logic [ram_address_width-1:0] mem_req_addr,
    input  logic                         mem_resp_valid,
    input  logic [pte_width-1:0]         mem_resp_data,
    output logic                         tlb_write_enable,
    output logic [paw-1:0]               tlb_key,
    output logic [paw-1:0]               tlb_value,
    output logic                         fault,
    output logic [paw-1:0]               fault_vpn,
    output logic                         busy,
    output logic [2:0]                   dbg_state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        L1_REQ  = 3'd1,
        L1_WAIT = 3'd2,
        L2_REQ  = 3'd3,
        L2_WAIT = 3'd4,
        RESP    = 3'd5
    } state_t;

    state_t         state, state_next;
    logic [paw-1:0] vpn_q;
    logic [paw-1:0] root_q;
    logic [paw-1:0] l1_ppn_q;
    logic           res_fault_q;

    // PTE fields of the incoming response
    logic           pte_v;
    logic [paw-1:0] pte_ppn;
    logic           unused_pte_bits;
    assign pte_v           = mem_resp_data[0];
    assign pte_ppn         = mem_resp_data[pte_width-1 -: paw];
    assign unused_pte_bits = ^mem_resp_data;

`ifdef PAGE_WALKER_SUPERPAGE_EN
    logic           pte_l;
    logic           sp_misaligned;
    logic [paw-1:0] sp_ppn;
    assign pte_l         = mem_resp_data[1];
    assign sp_misaligned = |mem_resp_data[page_offset_bits +: level_bits];
    assign sp_ppn        = {mem_resp_data[pte_width-1 -: level_bits], vpn_q[level_bits-1:0]};
`endif

    // State register; reset aborts any walk and drops outstanding responses
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (miss_valid) state_next = L1_REQ;
            L1_REQ:  if (mem_req_ready) state_next = L1_WAIT;
            L1_WAIT: begin
                if (mem_resp_valid) begin
                    if (!pte_v) state_next = RESP;
`ifdef PAGE_WALKER_SUPERPAGE_EN
                    else if (pte_l) state_next = RESP;
`endif
                    else state_next = L2_REQ;
                end
            end
            L2_REQ:  if (mem_req_ready) state_next = L2_WAIT;
            L2_WAIT: if (mem_resp_valid) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from the current state
    always_comb begin
        miss_ready       = (state == IDLE);
        busy             = (state != IDLE);
        mem_req_valid    = (state == L1_REQ) || (state == L2_REQ);
        mem_req_addr     = '0;
        tlb_write_enable = (state == RESP) && !res_fault_q;
        fault            = (state == RESP) && res_fault_q;
        dbg_state        = state;
        if (state == L1_REQ)
            mem_req_addr = {root_q, vpn_q[2*level_bits-1:level_bits], 2'b00};
        else if (state == L2_REQ)
            mem_req_addr = {l1_ppn_q, vpn_q[level_bits-1:0], 2'b00};
    end

    // Walk context and result registers; results are loaded on the way into RESP
    always_ff @(posedge clk) begin
        if (rst) begin
            vpn_q       <= '0;
            root_q      <= '0;
            l1_ppn_q    <= '0;
            res_fault_q <= 1'b0;
            tlb_key     <= '0;
            tlb_value   <= '0;
            fault_vpn   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss_valid) begin
                        vpn_q  <= miss_vpn;
                        root_q <= root_ppn;
                    end
                end
                L1_WAIT: begin
                    if (mem_resp_valid) begin
                        if (!pte_v) begin
                            res_fault_q <= 1'b1;
                            fault_vpn   <= vpn_q;
                        end
`ifdef PAGE_WALKER_SUPERPAGE_EN
                        else if (pte_l) begin
                            if (sp_misaligned) begin
                                res_fault_q <= 1'b1;
                                fault_vpn   <= vpn_q;
                            end else begin
                                res_fault_q <= 1'b0;
                                tlb_key     <= vpn_q;
                                tlb_value   <= sp_ppn;
                            end
                        end
`endif
                        else begin
                            l1_ppn_q <= pte_ppn;
                        end
                    end
                end
                L2_WAIT: begin
                    if (mem_resp_valid) begin
                        if (!pte_v) begin
                            res_fault_q <= 1'b1;
                            fault_vpn   <= vpn_q;
                        end else begin
                            res_fault_q <= 1'b0;
                            tlb_key     <= vpn_q;
                            tlb_value   <= pte_ppn;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_page_walker.sv
// tb_page_walker: directed and randomized walks against a page-table model.
// The bench plays the memory. Each walk's expected addresses and result come
// from a model that applies the page-table rules with plain arithmetic.
module tb_page_walker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [19:0] root_ppn = '0;
    logic        miss_valid = 1'b0;
    logic        miss_ready;
    logic [19:0] miss_vpn = '0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data = '0;
    logic        tlb_write_enable;
    logic [19:0] tlb_key;
    logic [19:0] tlb_value;
    logic        fault;
    logic [19:0] fault_vpn;
    logic        busy;
    logic [2:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    page_walker dut (
        .clk(clk), .rst(rst), .root_ppn(root_ppn),
        .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_vpn(miss_vpn),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .tlb_write_enable(tlb_write_enable), .tlb_key(tlb_key), .tlb_value(tlb_value),
        .fault(fault), .fault_vpn(fault_vpn), .busy(busy), .dbg_state(dbg_state)
    );

    // clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: byte addresses of the PTEs and the walk outcome
    task automatic model(input logic [19:0] vpn, input logic [19:0] root,
                         input logic [31:0] pte1, input logic [31:0] pte2,
                         output logic [31:0] addr1, output bit two_level,
                         output logic [31:0] addr2, output bit is_fault,
                         output logic [19:0] ppn);
        int unsigned hi, lo;
        hi        = vpn / 1024;
        lo        = vpn % 1024;
        addr1     = root * 4096 + hi * 4;
        addr2     = (pte1 / 4096) * 4096 + lo * 4;
        two_level = 0;
        is_fault  = 0;
        ppn       = '0;
        if (pte1 % 2 == 0) begin
            is_fault = 1;
        end
`ifdef PAGE_WALKER_SUPERPAGE_EN
        else if ((pte1 / 2) % 2 == 1) begin
            if ((pte1 / 4096) % 1024 != 0) is_fault = 1;
            else ppn = (pte1 / 4194304) * 1024 + lo;
        end
`endif
        else begin
            two_level = 1;
            if (pte2 % 2 == 0) is_fault = 1;
            else ppn = pte2 / 4096;
        end
    endtask

    task automatic check_busy_cycle(input string tag);
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_miss_ready"}, miss_ready, 0);
    endtask

    // Called at a negedge where the request should be presented
    task automatic serve_req(input logic [31:0] addr, input int dly, input bit stray);
        for (int i = 0; i < dly; i++) begin
            mem_req_ready = 1'b0;
            chk("req_valid_held", mem_req_valid, 1);
            chk("req_addr_stable", mem_req_addr, addr);
            check_busy_cycle("req_stall");
            @(negedge clk);
        end
        chk("req_valid", mem_req_valid, 1);
        chk("req_addr", mem_req_addr, addr);
        mem_req_ready = 1'b1;
        if (stray) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = $urandom;
        end
        @(negedge clk);
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
    endtask

    // Called at the first negedge of a *_WAIT state
    task automatic give_resp(input logic [31:0] data, input int dly);
        for (int i = 0; i < dly; i++) begin
            chk("wait_no_req", mem_req_valid, 0);
            check_busy_cycle("wait");
            @(negedge clk);
        end
        chk("wait_no_req", mem_req_valid, 0);
        mem_resp_valid = 1'b1;
        mem_resp_data  = data;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        mem_resp_data  = $urandom;
    endtask

    task automatic do_walk(input logic [19:0] vpn, input logic [19:0] root,
                           input logic [31:0] pte1, input logic [31:0] pte2,
                           input int rdly, input int sdly, input bit stray,
                           input bit hold, input logic [19:0] next_vpn);
        logic [31:0] a1, a2;
        logic [19:0] ppn;
        bit          two, flt;
        int          n, c0;
        model(vpn, root, pte1, pte2, a1, two, a2, flt, ppn);
        n = 0;
        while (miss_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("miss_ready_idle", miss_ready, 1);
        miss_valid = 1'b1;
        miss_vpn   = vpn;
        root_ppn   = root;
        c0         = cyc;
        @(negedge clk);
        if (hold) begin
            miss_vpn = next_vpn;
        end else begin
            miss_valid = 1'b0;
            miss_vpn   = 20'($urandom);
            root_ppn   = 20'($urandom);
        end
        serve_req(a1, rdly, stray);
        give_resp(pte1, sdly);
        if (two) begin
            serve_req(a2, rdly, stray);
            give_resp(pte2, sdly);
        end else begin
            chk("no_l2_req", mem_req_valid, 0);
        end
        chk("resp_we", tlb_write_enable, !flt);
        chk("resp_fault", fault, flt);
        chk("resp_busy", busy, 1);
        if (flt) begin
            chk("fault_vpn", fault_vpn, vpn);
        end else begin
            chk("tlb_key", tlb_key, vpn);
            chk("tlb_value", tlb_value, ppn);
        end
        if (rdly == 0 && sdly == 0) chk("latency", cyc - c0, two ? 5 : 3);
        @(negedge clk);
        chk("post_we", tlb_write_enable, 0);
        chk("post_fault", fault, 0);
        chk("post_miss_ready", miss_ready, 1);
        chk("post_busy", busy, 0);
        if (!flt) begin
            chk("tlb_key_hold", tlb_key, vpn);
            chk("tlb_value_hold", tlb_value, ppn);
        end
    endtask

    initial begin
        logic [31:0] a1, a2, p1, p2;
        logic [19:0] ppn, v, r;
        bit          two, flt;

        // reset
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_miss_ready", miss_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_req_valid", mem_req_valid, 0);
        chk("rst_req_addr", mem_req_addr, 0);
        chk("rst_we", tlb_write_enable, 0);
        chk("rst_key", tlb_key, 0);
        chk("rst_value", tlb_value, 0);
        chk("rst_fault", fault, 0);
        chk("rst_fault_vpn", fault_vpn, 0);
        chk("rst_state", dbg_state, 0);

        // two-level hit with literal addresses
        model(20'h01010, 20'h00100, 32'h0020_0001, 32'hAABA_0001, a1, two, a2, flt, ppn);
        chk("model_addr1", a1, 32'h0010_0010);
        chk("model_addr2", a2, 32'h0020_0040);
        chk("model_ppn", ppn, 20'hAABA0);
        do_walk(20'h01010, 20'h00100, 32'h0020_0001, 32'hAABA_0001, 0, 0, 0, 0, '0);

        // level-1 fault
        do_walk(20'h01010, 20'h00100, 32'h0020_0000, 32'hAABA_0001, 0, 0, 0, 0, '0);

        // backpressure with a second miss held through the first walk
        do_walk(20'h01010, 20'h00100, 32'h0020_0001, 32'hAABA_0001, 5, 0, 0, 1, 20'h0FFFF);
        do_walk(20'h0FFFF, 20'h00100, 32'h0030_0001, 32'h1234_5001, 0, 1, 1, 0, '0);

        // level-2 fault
        do_walk(20'h3ABCD, 20'h00777, 32'h0040_0001, 32'hFFFF_F000, 1, 2, 0, 0, '0);

        // reset in L2_WAIT, then a stray response
        chk("mid_miss_ready", miss_ready, 1);
        miss_valid = 1'b1;
        miss_vpn   = 20'h01010;
        root_ppn   = 20'h00100;
        @(negedge clk);
        miss_valid = 1'b0;
        serve_req(32'h0010_0010, 0, 0);
        give_resp(32'h0020_0001, 0);
        serve_req(32'h0020_0040, 0, 0);
        chk("mid_in_wait_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hAABA_0001;
        chk("mid_rst_miss_ready", miss_ready, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_state", dbg_state, 0);
        @(negedge clk);
        mem_resp_valid = 1'b0;
        chk("mid_rst_we", tlb_write_enable, 0);
        chk("mid_rst_fault", fault, 0);
        chk("mid_rst_req", mem_req_valid, 0);
        chk("mid_rst_key", tlb_key, 0);

`ifdef PAGE_WALKER_SUPERPAGE_EN
        // superpage leaf and misaligned superpage
        do_walk(20'h01010, 20'h00100, 32'hAA80_0003, 32'h0, 0, 0, 0, 0, '0);
        chk("sp_value", tlb_value, 20'hAA810);
        do_walk(20'h01010, 20'h00100, 32'hAA80_1003, 32'h0, 0, 0, 0, 0, '0);
`endif

        // randomized walks
        for (int i = 0; i < 40; i++) begin
            v  = 20'($urandom);
            r  = 20'($urandom);
            p1 = $urandom;
            p2 = $urandom;
            p1[0] = ($urandom_range(0, 9) != 0);
            p2[0] = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 1) == 1) p1[21:12] = '0;
            do_walk(v, r, p1, p2, $urandom_range(0, 3), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)), 0, '0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
